// File: rtl/reload_down_counter.sv
// Self-reloading down counter with a handshaked staged reload value and a one-shot mode.
// Define WRAP_COUNT_EN to add the saturating 8-bit reload counter output wraps_o.
module reload_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             rel_valid_i,
  input  logic [WIDTH-1:0] rel_val_i,
  output logic             rel_ready_o,
  input  logic             oneshot_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
`ifdef WRAP_COUNT_EN
  output logic [7:0]       wraps_o,
`endif
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] staged_q;
  logic             pending_q;
  logic             tc_q;

  logic xfer;
  logic terminal;

  assign xfer     = rel_valid_i & ~pending_q;
  // load_i wins over a terminal event in the same cycle
  assign terminal = (state_q == StRun) & en_i & (count_q == '0) & ~load_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      reload_q  <= '0;
      staged_q  <= '0;
      pending_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (xfer) begin
        staged_q  <= rel_val_i;
        pending_q <= 1'b1;
      end
      if (load_i) begin
        count_q  <= load_val_i;
        reload_q <= load_val_i;
        state_q  <= StRun;
        if (!xfer) pending_q <= 1'b0;
      end else if (terminal) begin
        tc_q <= 1'b1;
        if (oneshot_i) begin
          state_q <= StDone;
        end else if (pending_q) begin
          // xfer is impossible while pending, so clearing here cannot drop a new transfer
          reload_q  <= staged_q;
          count_q   <= staged_q;
          pending_q <= 1'b0;
        end else begin
          count_q <= reload_q;
        end
      end else if ((state_q == StRun) && en_i) begin
        count_q <= count_q - One;
      end
    end
  end

`ifdef WRAP_COUNT_EN
  logic [7:0] wraps_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wraps_q <= 8'd0;
    end else if (load_i) begin
      wraps_q <= 8'd0;
    end else if (terminal && !oneshot_i && (wraps_q != 8'hFF)) begin
      wraps_q <= wraps_q + 8'd1;
    end
  end

  assign wraps_o = wraps_q;
`endif

  assign rel_ready_o = ~pending_q;
  assign count_o     = count_q;
  assign tc_o        = tc_q;
  assign busy_o      = (state_q == StRun);

endmodule

// File: tb/tb_reload_down_counter.sv
// Scoreboard bench for reload_down_counter: stimulus queues hand-computed expectations,
// a monitor compares them one cycle later.
module tb_reload_down_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en_i, load_i, rel_valid_i, oneshot_i;
  logic [3:0] load_val_i, rel_val_i;
  logic       rel_ready_o, tc_o, busy_o;
  logic [3:0] count_o;
  logic [7:0] wraps;

  reload_down_counter #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (en_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .rel_valid_i(rel_valid_i),
    .rel_val_i  (rel_val_i),
    .rel_ready_o(rel_ready_o),
    .oneshot_i  (oneshot_i),
    .count_o    (count_o),
    .tc_o       (tc_o),
`ifdef WRAP_COUNT_EN
    .wraps_o    (wraps),
`endif
    .busy_o     (busy_o)
  );

`ifndef WRAP_COUNT_EN
  assign wraps = 8'd0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] c;
    logic       tc;
    logic       busy;
    logic       rdy;
    logic [7:0] w;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_step  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs; expected values describe the state after the next rising edge.
  task automatic step(input logic en, input logic ld, input logic [3:0] lv, input logic rv,
                      input logic [3:0] rval, input logic os, input logic [3:0] ec,
                      input logic etc, input logic eb, input logic er, input logic [7:0] ew);
    exp_t e;
    @(negedge clk);
    en_i = en; load_i = ld; load_val_i = lv; rel_valid_i = rv; rel_val_i = rval; oneshot_i = os;
    e.idx = n_step; e.c = ec; e.tc = etc; e.busy = eb; e.rdy = er; e.w = ew;
    q.push_back(e);
    n_step++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check($sformatf("s%0d count", e.idx), int'(count_o), int'(e.c));
        check($sformatf("s%0d tc", e.idx), int'(tc_o), int'(e.tc));
        check($sformatf("s%0d busy", e.idx), int'(busy_o), int'(e.busy));
        check($sformatf("s%0d ready", e.idx), int'(rel_ready_o), int'(e.rdy));
`ifdef WRAP_COUNT_EN
        check($sformatf("s%0d wraps", e.idx), int'(wraps), int'(e.w));
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0;
    en_i = 0; load_i = 0; load_val_i = 0; rel_valid_i = 0; rel_val_i = 0; oneshot_i = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset; en_i ignored
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);

    // Auto-reload, period 6
    step(1, 1, 5, 0, 0, 0,  5, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0,  4, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0,  3, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0,  2, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0,  5, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0,  4, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0,  3, 0, 1, 1, 1);

    // Staged reload of 2 offered at count 3
    step(1, 0, 0, 1, 2, 0,  2, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0,  2, 1, 1, 1, 2);
    step(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 2);
    step(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 2);
    step(1, 0, 0, 0, 0, 0,  2, 1, 1, 1, 3);

    // Enable gap at count 2
    step(0, 0, 0, 0, 0, 0,  2, 0, 1, 1, 3);
    step(0, 0, 0, 0, 0, 0,  2, 0, 1, 1, 3);
    step(0, 0, 0, 0, 0, 0,  2, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0,  2, 1, 1, 1, 4);
    step(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 4);
    step(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 4);

    // Load collides with terminal event and a transfer of 4
    step(1, 1, 9, 1, 4, 0,  9, 0, 1, 0, 0);
    for (int i = 8; i >= 0; i--) step(1, 0, 0, 0, 0, 0,  4'(i), 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0,  4, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0,  3, 0, 1, 1, 1);

    // One-shot from 3
    step(1, 1, 3, 0, 0, 1,  3, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1,  2, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0);
    // Load clears the pending stage taken while DONE
    step(1, 1, 7, 0, 0, 0,  7, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0,  6, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0,  5, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0,  4, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0,  3, 0, 1, 0, 0);

    // Asynchronous reset mid-run at count 3, checked between clock edges
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    en_i = 0; load_i = 0; rel_valid_i = 0; oneshot_i = 0;
    #1;
    check("async_rst count", int'(count_o), 0);
    check("async_rst tc", int'(tc_o), 0);
    check("async_rst busy", int'(busy_o), 0);
    check("async_rst ready", int'(rel_ready_o), 1);
    check("async_rst wraps", int'(wraps), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    check("queue drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reload_down_counter.md
Name: reload_down_counter

Overview:
- Self-reloading down counter. Counts from a programmed reload value down to 0, then reloads and emits a one-cycle terminal-count pulse.
- The counting direction is the reverse of the team's up-counting reload counter.
- Adds a staged reload value with a valid/ready handshake, so the period can change without glitching.
- Adds a one-shot mode.
- Used as a programmable period/tick generator for downstream blocks.

Parameters:
- WIDTH, 4, width of count, reload and staged values.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en_i  input  1  count enable; when low, the counter holds.
- load_i  input  1  immediate load: count and reload register take load_val_i.
- load_val_i  input  WIDTH  value for load_i.
- rel_valid_i  input  1  staged reload value offered.
- rel_val_i  input  WIDTH  staged reload value.
- rel_ready_o  output  1  staging slot empty; a transfer occurs when rel_valid_i & rel_ready_o.
- oneshot_i  input  1  1 = stop at 0 instead of reloading; sampled at each terminal event.
- count_o  output  WIDTH  current count.
- tc_o  output  1  registered terminal-count pulse.
- busy_o  output  1  state == RUN.
- wraps_o  output  8  reload counter; present only with WRAP_COUNT_EN.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, reset_n low):
  - state = IDLE
  - count_o = 0
  - reload register = 0
  - staged register = 0, pending = 0
  - tc_o = 0
  - rel_ready_o = 1
  - wraps_o = 0
- rel_ready_o = ~pending. A transfer sets pending and captures rel_val_i into the staged register.
- load_i (any state, highest priority):
  - count_o <= load_val_i; reload register <= load_val_i.
  - Clears any existing pending; state <= RUN; tc_o <= 0.
  - A transfer in the same cycle is still accepted: pending = 1 afterwards.
- IDLE and DONE:
  - Count holds; tc_o = 0; en_i is ignored.
  - Exit only via load_i.
- RUN, en_i = 0: count holds; tc_o = 0.
- RUN, en_i = 1, count_o > 0: count_o <= count_o - 1; tc_o <= 0.
- RUN, en_i = 1, count_o == 0 (terminal event): tc_o <= 1 for exactly one cycle, then:
  - oneshot_i = 1: state <= DONE; count_o stays 0; pending is retained.
  - else, pending = 1: reload register and count_o <= staged value; pending <= 0.
  - else: count_o <= reload register.
- A transfer in the same cycle as a terminal event is not applied at that event; it takes effect at the next terminal event.
- Period: reload value + 1 enabled cycles.
  - Reload = 0 gives tc_o high on every enabled cycle, with count_o fixed at 0.
- Arithmetic is unsigned WIDTH-bit. Decrement never underflows, because 0 always triggers the terminal event.
- Reset asserted mid-count returns to IDLE immediately (async), with all outputs at reset values.

Optional Feature:
- Macro: WRAP_COUNT_EN.
- Defined:
  - Adds output wraps_o (8-bit), incremented on each reloading terminal event; one-shot stops do not count.
  - Saturates at 255.
  - Cleared by reset and by load_i.
- Undefined: no wraps_o port and no associated logic; all other behaviour is identical.

Test Plan:
1. Reset: hold reset_n = 0 mid-run with count_o = 3 -> count_o = 0, tc_o = 0, busy_o = 0, rel_ready_o = 1, without waiting for a clock edge.
2. Auto-reload: load_i with load_val_i = 5, en_i = 1, oneshot_i = 0 -> count_o 5,4,3,2,1,0,5,4…; tc_o high on exactly the cycle count_o returns to 5; period 6. With WRAP_COUNT_EN, wraps_o steps 0 -> 1 on that cycle.
3. Staged reload: running with reload 5, stage 2 while count_o = 3 -> rel_ready_o = 0 until the terminal event; sequence continues 3,2,1,0,2,1,0,2; rel_ready_o = 1 after the first reload to 2.
4. One-shot: load_val_i = 3, oneshot_i = 1 -> count_o 3,2,1,0,0; tc_o pulses once; busy_o drops to 0 with state DONE; further en_i has no effect; then load_i with 7 -> RUN, count_o = 7.
5. Enable gaps: drop en_i at count_o = 2 for 3 cycles -> count_o holds 2, tc_o stays 0; resumes 1,0 once en_i returns high.
6. Load vs terminal collision: count_o = 0, en_i = 1, load_i = 1, load_val_i = 9, rel_valid_i = 1 with rel_val_i = 4 -> count_o = 9, tc_o = 0, rel_ready_o = 0; the next terminal event reloads to 4.
